decode_rename_fifo: RTL and testbench
=====================================

# decode_rename_fifo

Multi-lane buffer between the decode and rename stages. Each cycle it accepts up to IN_WIDTH decoded instructions (decode_rename_pack_t) from decode and presents up to OUT_WIDTH of them in program order to rename. It owns the per-lane space/occupancy handshakes on both sides, supports a single-cycle flush driven by commit, and raises a full flag for the CSR performance counter.

## Interface
- IN_WIDTH, `DECODE_WIDTH: number of push lanes (decode side).
- OUT_WIDTH, `RENAME_WIDTH: number of pop lanes (rename side).
- DEPTH, `DECODE_RENAME_FIFO_SIZE: entry count. Must be a power of two and ≥ max(IN_WIDTH, OUT_WIDTH).

- clk  in  1  clock; one clock, reset is synchronous and active-low.
- rst  in  1  reset; one clock, reset is synchronous and active-low.
- data_in[0:IN_WIDTH-1]  in  decode_rename_pack_t  entries offered by decode.
- data_in_enable  out  IN_WIDTH  bit i = 1 iff free entries > i.
- data_in_valid  in  IN_WIDTH  lanes decode wants written; contiguous from lane 0.
- push  in  1  write strobe qualifying data_in_valid.
- data_out[0:OUT_WIDTH-1]  out  decode_rename_pack_t  oldest entries, lane 0 oldest.
- data_out_valid  out  OUT_WIDTH  bit i = 1 iff occupied entries > i.
- data_pop_valid  in  OUT_WIDTH  lanes rename consumes; contiguous from lane 0.
- pop  in  1  read strobe qualifying data_pop_valid.
- flush  in  1  discard all contents.
- full  out  1  occupied == DEPTH; drives decode_csrf_decode_rename_fifo_full_add.
- count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- State: storage array (not reset); rptr and wptr, each $clog2(DEPTH) bits plus a wrap bit; count.
- Write lanes: n_w = length of the leading run of ones in (data_in_valid & data_in_enable) when push = 1, else 0. Lanes after the first zero are dropped and never written.
- Lane i writes slot (wptr+i) mod DEPTH for i < n_w. Then wptr += n_w.
- Read lanes: n_r = length of the leading run of ones in (data_pop_valid & data_out_valid) when pop = 1, else 0. Then rptr += n_r.
- data_out[i] = storage[(rptr+i) mod DEPTH]. This is combinational from the array and pointer. Contents are don't-care where data_out_valid[i] = 0.
- count_next = count + n_w − n_r.
- data_in_enable is derived from the current count only. Space freed by a same-cycle pop is not offered until the next cycle.
- Simultaneous push and pop are both honoured in full.
- flush = 1: rptr, wptr and count go to 0 next cycle. Push and pop in that cycle are ignored. Flush has priority over everything except rst.
- rst = 0 (sampled at clk): same effect as flush. rst wins over flush. Reset asserted mid-operation discards all entries in the following cycle.
- Wrap-around: pointers wrap modulo DEPTH. A lane group may straddle the wrap boundary.
- Full/empty: full = (count == DEPTH), which implies data_in_enable = 0. Empty (count == 0) implies data_out_valid = 0.

## Timing
- Reset values: data_in_enable = all ones, data_out_valid = 0, full = 0, count = 0. data_out is don't-care.
- Write-to-read latency is 1 cycle: an entry pushed at edge N is visible on data_out with its data_out_valid bit set after edge N. There is no same-cycle fall-through.
- All outputs are functions of registered state only. There is no combinational path from any input to any output.
- Pop takes effect at the clock edge: the next entries appear on lane 0 in the following cycle.

## Structure
- decode_rename_pack_t already lives in the common package. Add DECODE_RENAME_FIFO_SIZE to config.svh.
- One sub-module: lane_prefix_count, a leading-ones-run counter of parameterised width. It is instantiated once for n_w and once for n_r.
- Pointer/count logic and storage live in the top module.

## Test plan
Bench configuration: DEPTH = 8, IN_WIDTH = 2, OUT_WIDTH = 2.
- Reset then idle: release rst. Expect data_in_enable = 2'b11, data_out_valid = 0, full = 0, count = 0.
- Basic push: push with valid = 2'b11, pc = 0x100 and 0x104. Next cycle: data_out_valid = 2'b11, data_out[0].pc = 0x100, data_out[1].pc = 0x104, count = 2.
- Fill to full: 4 cycles of 2-lane push with no pop. Expect count = 8, full = 1, data_in_enable = 0. A further push is dropped and count stays 8.
- Single free entry: at count = 7, push 2'b11. Only lane 0 is written and count = 8. Also drive valid = 2'b10 when empty: nothing is written.
- Wrap and concurrency: run steady push-2/pop-2 for 10 cycles. Expect count stays constant. data_out pcs stay in strictly increasing order across the index 7→0 wrap.
- Flush and reset: with count = 5, assert flush while also pushing and popping. Next cycle count = 0 and data_out_valid = 0. Repeat with rst = 0 and flush = 1 together: same result.

Source files
------------

// File: rtl/decode_rename_fifo_pkg.sv
// Shared types and sizing for the decode -> rename buffer.
// The pack type mirrors the decode stage's output record.
package decode_rename_fifo_pkg;

   localparam int DECODE_WIDTH            = 2;
   localparam int RENAME_WIDTH            = 2;
   localparam int DECODE_RENAME_FIFO_SIZE = 8;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic        rd_valid;
      logic        is_branch;
      logic        is_mem;
   } decode_rename_pack_t;

   // Free slots are derived from occupancy; both share the count width.
   function automatic int unsigned free_entries(input int unsigned depth, input int unsigned used);
      return depth - used;
   endfunction

endpackage

// File: rtl/decode_rename_fifo_if.sv
// Handshake bundle between decode (master) and the decode/rename FIFO (slave).
// Both the push side and the pop side live in one bundle so the FIFO has a single port group.
interface decode_rename_fifo_if #(
   parameter int IN_WIDTH  = 2,
   parameter int OUT_WIDTH = 2,
   parameter int DEPTH     = 8
);
   import decode_rename_fifo_pkg::*;

   decode_rename_pack_t          data_in [IN_WIDTH];
   logic [IN_WIDTH-1:0]          data_in_enable;
   logic [IN_WIDTH-1:0]          data_in_valid;
   logic                         push;

   decode_rename_pack_t          data_out [OUT_WIDTH];
   logic [OUT_WIDTH-1:0]         data_out_valid;
   logic [OUT_WIDTH-1:0]         data_pop_valid;
   logic                         pop;

   logic                         flush;
   logic                         full;
   logic [$clog2(DEPTH):0]       count;

   modport master (
      output data_in, data_in_valid, push, data_pop_valid, pop, flush,
      input  data_in_enable, data_out, data_out_valid, full, count
   );

   modport slave (
      input  data_in, data_in_valid, push, data_pop_valid, pop, flush,
      output data_in_enable, data_out, data_out_valid, full, count
   );

endinterface

// File: rtl/decode_rename_fifo_lane_prefix_count.sv
// Length of the leading run of ones starting at bit 0.
// Lanes after the first zero never count, which keeps lane groups contiguous.
module lane_prefix_count #(
   parameter int WIDTH = 2,
   parameter int RW    = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] lanes,
   output logic [RW-1:0]    run
);

   logic stopped;

   always_comb begin
      run     = '0;
      stopped = 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
         if (!stopped && lanes[i]) begin
            run = run + RW'(1);
         end else begin
            stopped = 1'b1;
         end
      end
   end

endmodule

// File: rtl/decode_rename_fifo.sv
// Multi-lane circular buffer between decode and rename, program order preserved.
// All outputs come from registered pointers/count and the storage array only.
module decode_rename_fifo
   import decode_rename_fifo_pkg::*;
#(
   parameter int IN_WIDTH  = DECODE_WIDTH,
   parameter int OUT_WIDTH = RENAME_WIDTH,
   parameter int DEPTH     = DECODE_RENAME_FIFO_SIZE
) (
   input logic                  clk,
   input logic                  rst,
   decode_rename_fifo_if.slave  io
);

   localparam int PW  = $clog2(DEPTH);
   localparam int CW  = PW + 1;
   localparam int NWW = $clog2(IN_WIDTH + 1);
   localparam int NRW = $clog2(OUT_WIDTH + 1);

   decode_rename_pack_t storage [DEPTH];

   logic [PW:0]           wptr, wptr_next;
   logic [PW:0]           rptr, rptr_next;
   logic [CW-1:0]         count, count_next;
   logic [CW-1:0]         free_slots;

   logic [IN_WIDTH-1:0]   in_enable;
   logic [OUT_WIDTH-1:0]  out_valid;
   logic [IN_WIDTH-1:0]   write_req;
   logic [OUT_WIDTH-1:0]  read_req;
   logic [NWW-1:0]        n_w;
   logic [NRW-1:0]        n_r;

   logic [PW-1:0]         wslot [IN_WIDTH];
   logic [PW-1:0]         rslot [OUT_WIDTH];

   // Lane offers depend on the current count only, so space freed by a
   // same-cycle pop is not offered until the next cycle.
   always_comb begin
      free_slots = CW'(DEPTH) - count;
      in_enable  = '0;
      out_valid  = '0;
      for (int i = 0; i < IN_WIDTH; i++) begin
         in_enable[i] = (free_slots > CW'(i));
      end
      for (int i = 0; i < OUT_WIDTH; i++) begin
         out_valid[i] = (count > CW'(i));
      end
   end

   always_comb begin
      write_req = io.push ? (io.data_in_valid & in_enable) : '0;
      read_req  = io.pop  ? (io.data_pop_valid & out_valid) : '0;
   end

   lane_prefix_count #(.WIDTH(IN_WIDTH), .RW(NWW)) u_write_run (
      .lanes (write_req),
      .run   (n_w)
   );

   lane_prefix_count #(.WIDTH(OUT_WIDTH), .RW(NRW)) u_read_run (
      .lanes (read_req),
      .run   (n_r)
   );

   // Slot indices wrap by truncation because DEPTH is a power of two.
   always_comb begin
      for (int i = 0; i < IN_WIDTH; i++) begin
         wslot[i] = wptr[PW-1:0] + PW'(i);
      end
      for (int i = 0; i < OUT_WIDTH; i++) begin
         rslot[i] = rptr[PW-1:0] + PW'(i);
      end
   end

   always_comb begin
      wptr_next  = wptr + (PW+1)'(n_w);
      rptr_next  = rptr + (PW+1)'(n_r);
      count_next = count + CW'(n_w) - CW'(n_r);
   end

   always_ff @(posedge clk) begin
      if (!rst || io.flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         wptr  <= wptr_next;
         rptr  <= rptr_next;
         count <= count_next;
      end
   end

   // Storage is deliberately not reset; stale slots are masked by the valids.
   always_ff @(posedge clk) begin
      if (rst && !io.flush) begin
         for (int i = 0; i < IN_WIDTH; i++) begin
            if (NWW'(i) < n_w) begin
               storage[wslot[i]] <= io.data_in[i];
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < OUT_WIDTH; i++) begin
         io.data_out[i] = storage[rslot[i]];
      end
      io.data_in_enable = in_enable;
      io.data_out_valid = out_valid;
      io.full           = (count == CW'(DEPTH));
      io.count          = count;
   end

endmodule

// File: tb/tb_decode_rename_fifo.sv
// Directed plus randomized bench for decode_rename_fifo against a queue model.
// The model tracks occupancy as a plain queue of entries in program order.
module tb_decode_rename_fifo;
   import decode_rename_fifo_pkg::*;

   localparam int IW = 2;
   localparam int OW = 2;
   localparam int D  = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;

   int tests = 0;
   int fails = 0;
   logic [31:0] next_pc = 32'h100;

   decode_rename_pack_t mq[$];

   decode_rename_fifo_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(D)) io ();

   decode_rename_fifo #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(D)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   always #5 clk = ~clk;

   task automatic setLanes();
      for (int i = 0; i < IW; i++) begin
         io.data_in[i].pc        = next_pc + 32'(4 * i);
         io.data_in[i].instr     = $urandom;
         io.data_in[i].rd        = 5'($urandom);
         io.data_in[i].rs1       = 5'($urandom);
         io.data_in[i].rs2       = 5'($urandom);
         io.data_in[i].rd_valid  = 1'($urandom);
         io.data_in[i].is_branch = 1'($urandom);
         io.data_in[i].is_mem    = 1'($urandom);
      end
      next_pc = next_pc + 32'(4 * IW);
   endtask

   task automatic checkOutput();
      int sz;
      logic [IW-1:0] exp_en;
      logic [OW-1:0] exp_v;
      sz = mq.size();
      for (int i = 0; i < IW; i++) exp_en[i] = ((D - sz) > i);
      for (int i = 0; i < OW; i++) exp_v[i] = (sz > i);

      tests++;
      assert (io.count === 4'(sz)) else begin
         fails++;
         $error("[TB] FAIL count observed=%0d expected=%0d", io.count, sz);
      end
      tests++;
      assert (io.full === (sz == D)) else begin
         fails++;
         $error("[TB] FAIL full observed=%b expected=%b", io.full, (sz == D));
      end
      tests++;
      assert (io.data_in_enable === exp_en) else begin
         fails++;
         $error("[TB] FAIL data_in_enable observed=%b expected=%b", io.data_in_enable, exp_en);
      end
      tests++;
      assert (io.data_out_valid === exp_v) else begin
         fails++;
         $error("[TB] FAIL data_out_valid observed=%b expected=%b", io.data_out_valid, exp_v);
      end
      for (int i = 0; i < OW; i++) begin
         if (i < sz) begin
            tests++;
            assert (io.data_out[i] === mq[i]) else begin
               fails++;
               $error("[TB] FAIL data_out[%0d] observed pc=%h instr=%h expected pc=%h instr=%h",
                      i, io.data_out[i].pc, io.data_out[i].instr, mq[i].pc, mq[i].instr);
            end
         end
      end
   endtask

   // Drives one cycle of inputs, advances the queue model at the edge, then checks.
   task automatic applyStimulus(input logic [IW-1:0] valid, input logic do_push,
                                input logic [OW-1:0] pop_valid, input logic do_pop,
                                input logic do_flush, input logic rst_v);
      decode_rename_pack_t lanes [IW];
      int nw;
      int nr;
      int free_now;
      int occ_now;
      io.data_in_valid  = valid;
      io.push           = do_push;
      io.data_pop_valid = pop_valid;
      io.pop            = do_pop;
      io.flush          = do_flush;
      rst               = rst_v;
      for (int i = 0; i < IW; i++) lanes[i] = io.data_in[i];
      occ_now  = mq.size();
      free_now = D - occ_now;
      nw = 0;
      nr = 0;
      if (do_push) begin
         for (int i = 0; i < IW; i++) begin
            if (valid[i] && i < free_now) nw++;
            else break;
         end
      end
      if (do_pop) begin
         for (int i = 0; i < OW; i++) begin
            if (pop_valid[i] && i < occ_now) nr++;
            else break;
         end
      end
      @(posedge clk);
      if (!rst_v || do_flush) begin
         mq.delete();
      end else begin
         repeat (nr) void'(mq.pop_front());
         for (int i = 0; i < nw; i++) mq.push_back(lanes[i]);
      end
      #1;
      checkOutput();
   endtask

   initial begin
      logic [31:0] prev_pc;
      for (int i = 0; i < IW; i++) io.data_in[i] = '0;
      io.data_in_valid  = '0;
      io.push           = 1'b0;
      io.data_pop_valid = '0;
      io.pop            = 1'b0;
      io.flush          = 1'b0;

      // reset, then idle
      applyStimulus(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      applyStimulus(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
      applyStimulus(2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
      tests++;
      assert (io.data_in_enable === 2'b11 && io.data_out_valid === 2'b00 && io.full === 1'b0)
      else begin
         fails++;
         $error("[TB] FAIL reset_idle observed en=%b v=%b full=%b expected en=11 v=00 full=0",
                io.data_in_enable, io.data_out_valid, io.full);
      end

      // basic push of 0x100/0x104
      setLanes();
      applyStimulus(2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
      tests++;
      assert (io.data_out[0].pc === 32'h100 && io.data_out[1].pc === 32'h104 && io.count === 4'd2)
      else begin
         fails++;
         $error("[TB] FAIL basic_push observed pc0=%h pc1=%h count=%0d expected 100 104 2",
                io.data_out[0].pc, io.data_out[1].pc, io.count);
      end

      // fill to full, then one dropped push
      repeat (3) begin
         setLanes();
         applyStimulus(2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
      end
      setLanes();
      applyStimulus(2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
      tests++;
      assert (io.count === 4'd8 && io.full === 1'b1 && io.data_in_enable === 2'b00) else begin
         fails++;
         $error("[TB] FAIL full_drop observed count=%0d full=%b en=%b expected 8 1 00",
                io.count, io.full, io.data_in_enable);
      end

      // single free entry accepts only lane 0
      applyStimulus(2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1);
      setLanes();
      applyStimulus(2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
      tests++;
      assert (io.count === 4'd8) else begin
         fails++;
         $error("[TB] FAIL single_free observed count=%0d expected 8", io.count);
      end

      // non-contiguous valid when empty writes nothing
      applyStimulus(2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
      setLanes();
      applyStimulus(2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
      tests++;
      assert (io.count === 4'd0) else begin
         fails++;
         $error("[TB] FAIL gap_valid observed count=%0d expected 0", io.count);
      end

      // steady push-2/pop-2 across the wrap point
      repeat (2) begin
         setLanes();
         applyStimulus(2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
      end
      prev_pc = io.data_out[0].pc;
      for (int c = 0; c < 10; c++) begin
         setLanes();
         applyStimulus(2'b11, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1);
         tests++;
         assert (io.count === 4'd4 && io.data_out[1].pc > io.data_out[0].pc &&
                 io.data_out[0].pc > prev_pc) else begin
            fails++;
            $error("[TB] FAIL wrap_order observed count=%0d pc0=%h pc1=%h prev=%h expected 4 increasing",
                   io.count, io.data_out[0].pc, io.data_out[1].pc, prev_pc);
         end
         prev_pc = io.data_out[0].pc;
      end

      // flush at count 5 while pushing and popping
      setLanes();
      applyStimulus(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
      setLanes();
      applyStimulus(2'b11, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1);
      tests++;
      assert (io.count === 4'd0 && io.data_out_valid === 2'b00) else begin
         fails++;
         $error("[TB] FAIL flush observed count=%0d v=%b expected 0 00", io.count, io.data_out_valid);
      end

      // reset together with flush at count 5
      repeat (2) begin
         setLanes();
         applyStimulus(2'b11, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
      end
      setLanes();
      applyStimulus(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
      setLanes();
      applyStimulus(2'b11, 1'b1, 2'b11, 1'b1, 1'b1, 1'b0);
      tests++;
      assert (io.count === 4'd0 && io.data_out_valid === 2'b00) else begin
         fails++;
         $error("[TB] FAIL rst_flush observed count=%0d v=%b expected 0 00", io.count, io.data_out_valid);
      end

      // randomized traffic with occasional flush/reset
      for (int c = 0; c < 300; c++) begin
         setLanes();
         applyStimulus(2'($urandom), ($urandom_range(0, 3) != 0),
                       2'($urandom), ($urandom_range(0, 2) != 0),
                       ($urandom_range(0, 24) == 0), ($urandom_range(0, 49) != 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
